syncfifo_rr_push_ctrl: RTL and testbench
========================================

Name: syncfifo_rr_push_ctrl

Overview:
Controller that shares one synchronous FIFO storage array between NUM_REQ producers.
- Round-robin arbitration grants at most one push per cycle.
- Owns the read/write pointers, full/empty logic and occupancy; drives write/read addresses to an external register-file/SRAM.
- Presents a single val/rdy consumer port.
- Sits in front of the systolic array input buffers, where several stream sources feed one lane FIFO.

Parameters:
NUM_REQ, 4, number of producer ports (>=2)
DEPTH, 8, FIFO entries; must be a power of 2 (>=2)
DATA_W, 32, payload width per entry
PTR_WIDTH, $clog2(DEPTH)+1, pointer width including wrap bit
ID_W, $clog2(NUM_REQ), requester-index width

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_val  in  NUM_REQ  producer valid, one bit per requester
req_msg  in  NUM_REQ*DATA_W  producer payloads; requester i occupies bits [i*DATA_W +: DATA_W]
req_rdy  out  NUM_REQ  producer ready (one-hot or zero)
resp_val  out  1  head entry valid
resp_rdy  in  1  consumer ready
resp_msg  out  DATA_W(+ID_W)  head payload, equal to mem_rdata
mem_wen  out  1  storage write enable
mem_waddr  out  PTR_WIDTH-1  storage write address
mem_wdata  out  DATA_W(+ID_W)  storage write data
mem_raddr  out  PTR_WIDTH-1  storage read address
mem_rdata  in  DATA_W(+ID_W)  storage combinational read data
count  out  PTR_WIDTH  current occupancy, 0..DEPTH
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0

Behaviour:
- Reset
  - rst_n low asynchronously clears w_ptr, r_ptr and prio to 0, including mid-transfer; no partial push or pop survives.
  - While rst_n is low, req_rdy=0, mem_wen=0 and resp_val=0 are forced.
  - After reset: count=0, empty=1, full=0.
- Pointers
  - full = (w_ptr MSB != r_ptr MSB) & (low bits equal).
  - empty = (w_ptr == r_ptr).
  - count = w_ptr - r_ptr, modulo 2^PTR_WIDTH.
  - Pointers wrap naturally at 2^PTR_WIDTH.
- Arbitration (combinational)
  - Search req_val starting at index prio, ascending modulo NUM_REQ; the first set bit is the grant g.
  - req_rdy[g] = ~full; all other req_rdy bits are 0.
  - No valid requests gives req_rdy=0.
  - req_rdy may depend on req_val; producers must not make req_val depend on req_rdy.
- Push (a "push cycle")
  - Occurs when req_val[g] & ~full.
  - mem_wen=1, mem_waddr = w_ptr[PTR_WIDTH-2:0], mem_wdata = payload of g.
  - Posedge: w_ptr+1, prio = (g+1) mod NUM_REQ.
  - With no push, prio holds.
  - Starvation bound: a continuously valid requester is granted within NUM_REQ push cycles.
- Pop
  - resp_val = ~empty; mem_raddr = r_ptr[PTR_WIDTH-2:0]; resp_msg = mem_rdata.
  - resp_val & resp_rdy advances r_ptr at the posedge.
- Latency: an entry pushed at edge k is visible on resp_val in the cycle after edge k. There is no bypass; an empty FIFO never presents same-cycle data.
- Simultaneous push and pop
  - Non-full, non-empty: both pointers advance and count is unchanged.
  - Full: push is blocked even if a pop occurs that cycle, because full is not relieved combinationally.
  - Empty: only the push occurs.
- Gating: full blocks all req_rdy without changing prio.

Optional Feature:
Macro SYNCFIFO_RR_PUSH_CTRL_ID_TAG_EN.
- Defined:
  - mem_wdata, mem_rdata and resp_msg widen by ID_W.
  - Upper ID_W bits = granted index g, captured with the payload; the consumer receives the source id per entry.
  - Requires NUM_REQ >= 2.
- Undefined: widths are exactly DATA_W and no id is stored.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then 1 with req_val=0 -> count=0, empty=1, resp_val=0, req_rdy=0, mem_wen=0.
- Round-robin fairness: NUM_REQ=4, all req_val=1, resp_rdy=1 for 12 cycles -> grants 0,1,2,3,0,1,2,3,... each exactly 3 times; count stays <=1.
- Full boundary: DEPTH=8, req_val[2]=1 with distinct payloads, resp_rdy=0 -> 8 pushes, then full=1, count=8, req_rdy=0. resp_rdy=1 for one cycle -> first payload popped; req_rdy[2] rises the following cycle.
- Wrap-around ordering: push/pop 20 entries through DEPTH=8 with random resp_rdy -> output order equals push order; w_ptr wraps past 16 with correct full/empty.
- Async reset mid-stream: count=5 with a push active; drop rst_n between edges -> req_rdy, mem_wen and resp_val go 0 immediately, and count=0 after release.
- ID tag (macro on): req_val=4'b1010 for two pushes -> resp_msg upper ID_W bits read 1 then 3.

Source files
------------

// File: rtl/syncfifo_rr_push_ctrl.sv
// -----------------------------------------------------------------------------
// syncfifo_rr_push_ctrl
//
// Shares one synchronous FIFO storage array (external register file / SRAM)
// between NUM_REQ producers. A round-robin arbiter grants at most one push per
// cycle. This block owns the read/write pointers, full/empty/occupancy, and
// drives the storage write/read ports. One val/rdy consumer port drains the
// head entry. There is no bypass: an entry written at a clock edge is first
// visible on resp_val in the cycle after that edge.
//
// Optional feature (macro SYNCFIFO_RR_PUSH_CTRL_ID_TAG_EN):
//   When defined, each stored entry carries the granted requester index in its
//   upper ID_W bits, so the consumer learns the source of every entry.
//   When undefined, entries are exactly DATA_W wide.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   req_val    [NUM_REQ]         producer valid
//   req_msg    [NUM_REQ*DATA_W]  producer payloads, requester i at [i*DATA_W +: DATA_W]
//   req_rdy    [NUM_REQ]         producer ready (one-hot or zero)
//   resp_val                     head entry valid
//   resp_rdy                     consumer ready
//   resp_msg   [MSG_W]           head entry (mirrors mem_rdata)
//   mem_wen                      storage write enable
//   mem_waddr  [PTR_WIDTH-1]     storage write address
//   mem_wdata  [MSG_W]           storage write data
//   mem_raddr  [PTR_WIDTH-1]     storage read address
//   mem_rdata  [MSG_W]           storage combinational read data
//   count      [PTR_WIDTH]       occupancy 0..DEPTH
//   full / empty                 occupancy == DEPTH / occupancy == 0
// -----------------------------------------------------------------------------
module syncfifo_rr_push_ctrl #(
    parameter int NUM_REQ   = 4,
    parameter int DEPTH     = 8,
    parameter int DATA_W    = 32,
    parameter int PTR_WIDTH = $clog2(DEPTH) + 1,
    parameter int ID_W      = $clog2(NUM_REQ),
`ifdef SYNCFIFO_RR_PUSH_CTRL_ID_TAG_EN
    localparam int MSG_W    = DATA_W + ID_W
`else
    localparam int MSG_W    = DATA_W
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_val,
    input  logic [NUM_REQ*DATA_W-1:0]   req_msg,
    output logic [NUM_REQ-1:0]          req_rdy,
    output logic                        resp_val,
    input  logic                        resp_rdy,
    output logic [MSG_W-1:0]            resp_msg,
    output logic                        mem_wen,
    output logic [PTR_WIDTH-2:0]        mem_waddr,
    output logic [MSG_W-1:0]            mem_wdata,
    output logic [PTR_WIDTH-2:0]        mem_raddr,
    input  logic [MSG_W-1:0]            mem_rdata,
    output logic [PTR_WIDTH-1:0]        count,
    output logic                        full,
    output logic                        empty
);

    logic [PTR_WIDTH-1:0] w_ptr;
    logic [PTR_WIDTH-1:0] r_ptr;
    logic [ID_W-1:0]      prio;

    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic [DATA_W-1:0]    grant_data;
    logic                 push;
    logic                 pop;

    // Pointer-derived status; the extra MSB distinguishes full from empty.
    assign full  = (w_ptr[PTR_WIDTH-1] != r_ptr[PTR_WIDTH-1]) &&
                   (w_ptr[PTR_WIDTH-2:0] == r_ptr[PTR_WIDTH-2:0]);
    assign empty = (w_ptr == r_ptr);
    assign count = w_ptr - r_ptr;

    // Round-robin search starting at prio. Walking the offsets from highest to
    // lowest and overwriting on every hit leaves the smallest offset, i.e. the
    // first set bit at or after prio (mod NUM_REQ).
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(prio) + k) % NUM_REQ;
            if (req_val[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign grant_data = req_msg[grant_idx*DATA_W +: DATA_W];

    // Full blocks the push outright; a same-cycle pop does not relieve it.
    // rst_n gating keeps the write strobe quiet while reset is held.
    assign push = grant_found && !full && rst_n;
    assign pop  = resp_val && resp_rdy;

    always_comb begin
        req_rdy = '0;
        if (push)
            req_rdy[grant_idx] = 1'b1;
    end

    assign mem_wen   = push;
    assign mem_waddr = w_ptr[PTR_WIDTH-2:0];
`ifdef SYNCFIFO_RR_PUSH_CTRL_ID_TAG_EN
    assign mem_wdata = {grant_idx, grant_data};
`else
    assign mem_wdata = grant_data;
`endif

    assign resp_val  = !empty && rst_n;
    assign mem_raddr = r_ptr[PTR_WIDTH-2:0];
    assign resp_msg  = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
            prio  <= '0;
        end else begin
            if (push) begin
                w_ptr <= w_ptr + PTR_WIDTH'(1);
                // Next search starts just past the winner; holds when idle or full.
                if (grant_idx == ID_W'(NUM_REQ - 1))
                    prio <= '0;
                else
                    prio <= grant_idx + ID_W'(1);
            end
            if (pop)
                r_ptr <= r_ptr + PTR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_syncfifo_rr_push_ctrl.sv
module tb_syncfifo_rr_push_ctrl;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 8;
    localparam int DATA_W  = 32;
    localparam int PW      = 4;
    localparam int ID_W    = 2;
`ifdef SYNCFIFO_RR_PUSH_CTRL_ID_TAG_EN
    localparam int MSG_W   = DATA_W + ID_W;
`else
    localparam int MSG_W   = DATA_W;
`endif

    logic                       clk;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req_val;
    logic [NUM_REQ*DATA_W-1:0]  req_msg;
    logic [NUM_REQ-1:0]         req_rdy;
    logic                       resp_val;
    logic                       resp_rdy;
    logic [MSG_W-1:0]           resp_msg;
    logic                       mem_wen;
    logic [PW-2:0]              mem_waddr;
    logic [MSG_W-1:0]           mem_wdata;
    logic [PW-2:0]              mem_raddr;
    logic [MSG_W-1:0]           mem_rdata;
    logic [PW-1:0]              count;
    logic                       full;
    logic                       empty;

    syncfifo_rr_push_ctrl #(
        .NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_val(req_val), .req_msg(req_msg), .req_rdy(req_rdy),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .count(count), .full(full), .empty(empty)
    );

    // Storage model: synchronous write, combinational read.
    logic [MSG_W-1:0] mem [DEPTH];
    always @(posedge clk) if (mem_wen) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [MSG_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    endtask

    function automatic logic [MSG_W-1:0] exp_item(input int g, input logic [DATA_W-1:0] d);
`ifdef SYNCFIFO_RR_PUSH_CTRL_ID_TAG_EN
        return {ID_W'(g), d};
`else
        return d;
`endif
    endfunction

    // Monitor: every accepted head entry is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && resp_val && resp_rdy) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 64'(resp_msg), 64'hDEAD);
            else chk("pop_data", 64'(resp_msg), 64'(exp_q.pop_front()));
        end
    end

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk); #1;
        req_val  = '0;
        resp_rdy = 1'b1;
        @(negedge clk);
        while (!empty && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", empty, 1'b1);
        chk("drain_count", count, 0);
    endtask

    initial begin
        logic [NUM_REQ-1:0] oh;
        int k, mcount, r;
        bit will_push, will_pop;

        rst_n    = 1'b0;
        req_val  = '0;
        req_msg  = '0;
        resp_rdy = 1'b0;

        // ---- reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_resp_val", resp_val, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_count", count, 0);
        chk("idle_empty", empty, 1);
        chk("idle_full", full, 0);
        chk("idle_resp_val", resp_val, 0);
        chk("idle_req_rdy", req_rdy, 0);
        chk("idle_mem_wen", mem_wen, 0);

        // ---- round-robin fairness: grants cycle 0,1,2,3 three times
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            req_val  = '1;
            resp_rdy = 1'b1;
            for (int i = 0; i < NUM_REQ; i++)
                req_msg[i*DATA_W +: DATA_W] = 32'h1000 + 32'(c*16 + i);
            exp_q.push_back(exp_item(c % 4, 32'h1000 + 32'(c*16 + c % 4)));
            oh = '0;
            oh[c % 4] = 1'b1;
            @(negedge clk);
            chk("rr_grant", req_rdy, oh);
            chk("rr_count_le1", count <= 1, 1);
        end
        drain();

        // ---- full boundary on requester 2
        for (int j = 0; j < DEPTH; j++) begin
            @(posedge clk); #1;
            req_val  = 4'b0100;
            resp_rdy = 1'b0;
            req_msg[2*DATA_W +: DATA_W] = 32'hA000 + 32'(j);
            exp_q.push_back(exp_item(2, 32'hA000 + 32'(j)));
            @(negedge clk);
            chk("fill_grant", req_rdy, 4'b0100);
        end
        @(posedge clk); #1;
        req_msg[2*DATA_W +: DATA_W] = 32'hA008;
        @(negedge clk);
        chk("full_flag", full, 1);
        chk("full_count", count, 8);
        chk("full_req_rdy", req_rdy, 0);
        chk("full_mem_wen", mem_wen, 0);
        chk("full_resp_val", resp_val, 1);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("full_pop_blocks_push", req_rdy, 0);
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        exp_q.push_back(exp_item(2, 32'hA008));
        @(negedge clk);
        chk("after_pop_grant", req_rdy, 4'b0100);
        chk("after_pop_count", count, 7);
        drain();

        // ---- wrap-around ordering against an occupancy model
        k = 0;
        mcount = 0;
        for (int cyc = 0; cyc < 300 && k < 20; cyc++) begin
            @(posedge clk); #1;
            r = k % 4;
            req_val = '0;
            req_val[r] = 1'b1;
            req_msg[r*DATA_W +: DATA_W] = 32'hC000 + 32'(k);
            resp_rdy  = ($urandom_range(0, 2) == 0);
            will_push = (mcount < DEPTH);
            will_pop  = resp_rdy && (mcount > 0);
            if (will_push) exp_q.push_back(exp_item(r, 32'hC000 + 32'(k)));
            oh = '0;
            if (will_push) oh[r] = 1'b1;
            @(negedge clk);
            chk("wrap_count", count, 64'(mcount));
            chk("wrap_full", full, mcount == DEPTH);
            chk("wrap_empty", empty, mcount == 0);
            chk("wrap_req_rdy", req_rdy, oh);
            mcount = mcount + int'(will_push) - int'(will_pop);
            if (will_push) k++;
        end
        chk("wrap_all_pushed", k, 20);
        drain();

        // ---- async reset mid-stream
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            req_val  = 4'b0001;
            resp_rdy = 1'b0;
            req_msg[0 +: DATA_W] = 32'hB000 + 32'(j);
            exp_q.push_back(exp_item(0, 32'hB000 + 32'(j)));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_count", count, 5);
        chk("mid_mem_wen", mem_wen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_rdy", req_rdy, 0);
        chk("arst_mem_wen", mem_wen, 0);
        chk("arst_resp_val", resp_val, 0);
        chk("arst_count", count, 0);
        exp_q.delete();
        @(posedge clk); #1;
        req_val = '0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("post_rst_count", count, 0);
        chk("post_rst_empty", empty, 1);

        // ---- source id: req_val 1010 grants 1 then 3
        for (int i = 0; i < NUM_REQ; i++)
            req_msg[i*DATA_W +: DATA_W] = 32'hD000 + 32'(i);
        @(posedge clk); #1;
        req_val = 4'b1010;
        exp_q.push_back(exp_item(1, 32'hD001));
        @(negedge clk);
        chk("id_grant0", req_rdy, 4'b0010);
        @(posedge clk); #1;
        exp_q.push_back(exp_item(3, 32'hD003));
        @(negedge clk);
        chk("id_grant1", req_rdy, 4'b1000);
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
